// File: rtl/temp_comparator.sv
// ============================================================================
// Module   : temp_comparator
// Purpose  : Hot/cold/in-band temperature classifier with hysteresis and
//            debounce; optional 4-sample moving average via TEMP_FILTER_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module temp_comparator #(
  parameter int unsigned HYST     = 2,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] temp_meas,
  input  logic [7:0] temp_set,
  output logic [1:0] temp_comp,
  output logic       comp_valid,
  output logic       comp_change
);

  localparam logic [1:0] c_hot  = 2'b10;
  localparam logic [1:0] c_cold = 2'b01;
  localparam logic [1:0] c_band = 2'b00;
  localparam logic [1:0] c_none = 2'b11;
  localparam logic [8:0] c_hyst = 9'(HYST);
  localparam logic [4:0] c_deb  = 5'(DEBOUNCE);

  logic [1:0] comp_q, comp_d;
  logic       valid_q, valid_d;
  logic       change_q, change_d;
  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] cnt_next;

  logic [7:0] v;
  logic       v_ready;

`ifdef TEMP_FILTER_EN
  // Window = current sample plus the three previously accepted ones.
  logic [7:0] hist_q [3];
  logic [2:0] fill_q;
  logic [9:0] sum;

  assign sum     = 10'(temp_meas) + 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]);
  assign v       = 8'(sum >> 2);
  assign v_ready = (fill_q >= 3'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q[0] <= 8'd0;
      hist_q[1] <= 8'd0;
      hist_q[2] <= 8'd0;
      fill_q    <= 3'd0;
    end else if (sample_valid) begin
      hist_q[0] <= temp_meas;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
      if (fill_q != 3'd4) begin
        fill_q <= fill_q + 3'd1;
      end
    end
  end
`else
  assign v       = temp_meas;
  assign v_ready = 1'b1;
`endif

  logic [8:0] v9, set9, hot_th;
  logic [1:0] base_cls, raw_cls;

  assign v9     = {1'b0, v};
  assign set9   = {1'b0, temp_set};
  assign hot_th = set9 + c_hyst;

  always_comb begin
    base_cls = c_band;
    if (v9 > hot_th) begin
      base_cls = c_hot;
    end else if ((v9 + c_hyst) < set9) begin
      base_cls = c_cold;
    end
    raw_cls = base_cls;
    // Once hot or cold, stay there until V crosses back over the setpoint.
    if ((comp_q == c_hot) && (v9 > set9)) begin
      raw_cls = c_hot;
    end
    if ((comp_q == c_cold) && (v9 < set9)) begin
      raw_cls = c_cold;
    end
  end

  always_comb begin
    comp_d   = comp_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    cnt_next = 5'd0;
    if (sample_valid && v_ready) begin
      if (comp_q == c_none) begin
        comp_d  = raw_cls;
        valid_d = 1'b1;
      end else if (raw_cls == comp_q) begin
        cnt_d = 4'd0;
      end else begin
        if (raw_cls == cand_q) begin
          cnt_next = {1'b0, cnt_q} + 5'd1;
        end else begin
          cand_d   = raw_cls;
          cnt_next = 5'd1;
        end
        if (cnt_next >= c_deb) begin
          comp_d   = raw_cls;
          cnt_d    = 4'd0;
          change_d = ~change_q;
        end else begin
          cnt_d = cnt_next[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      comp_q   <= c_none;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      cand_q   <= 2'b00;
      cnt_q    <= 4'd0;
    end else begin
      comp_q   <= comp_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
    end
  end

  assign temp_comp   = comp_q;
  assign comp_valid  = valid_q;
  assign comp_change = change_q;

endmodule

`default_nettype wire
